// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared definitions.
// States, owner encoding and counter width.
package mem_arb_pkg;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and MMU signals of the memory arbiter.
// slave = arbiter side, master = CPU stages plus MMU side.
interface mem_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;

   logic        mem_req;
   logic        mem_we;
   logic        mem_byte;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        mmu_read;
   logic        mmu_write;
   logic        mmu_bytemode;
   logic [31:0] mmu_addr;
   logic [31:0] mmu_wdata;
   logic [31:0] mmu_rdata;

   logic        stall_req;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_ack,
      input  mem_req, mem_we, mem_byte,
      input  mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      output mmu_read, mmu_write,
      output mmu_bytemode,
      output mmu_addr, mmu_wdata,
      input  mmu_rdata,
      output stall_req
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_ack,
      output mem_req, mem_we, mem_byte,
      output mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      input  mmu_read, mmu_write,
      input  mmu_bytemode,
      input  mmu_addr, mmu_wdata,
      output mmu_rdata,
      input  stall_req
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter: IF vs MEM stage.
// MEM has priority; one access at a time.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] WAIT_INIT =
      CNT_W'(WAIT_CYCLES);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic             byte_q, byte_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      mem_rdata_q, mem_rdata_d;
   logic             if_ack_w;
   logic             mem_ack_w;

   // Grant, hold and completion sequencing.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      byte_d      = byte_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               owner_d = OWN_MEM;
               addr_d  = bus.mem_addr;
               byte_d  = bus.mem_byte;
               rd_d    = ~bus.mem_we;
               wr_d    = bus.mem_we;
               if (bus.mem_we) begin
                  wdata_d = bus.mem_wdata;
               end
               cnt_d   = WAIT_INIT;
               state_d = ACCESS;
            end else if (bus.if_req) begin
               owner_d = OWN_IF;
               addr_d  = bus.if_addr;
               byte_d  = 1'b0;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               cnt_d   = WAIT_INIT;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (rd_q) begin
                  if (owner_q == OWN_IF) begin
                     if_rdata_d = bus.mmu_rdata;
                  end else begin
                     mem_rdata_d = bus.mmu_rdata;
                  end
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               byte_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered MMU drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         byte_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         byte_q      <= byte_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_ack_w  = (state_q == DONE) &&
                      (owner_q == OWN_IF);
   assign mem_ack_w = (state_q == DONE) &&
                      (owner_q == OWN_MEM);

   assign bus.if_ack       = if_ack_w;
   assign bus.mem_ack      = mem_ack_w;
   assign bus.if_rdata     = if_rdata_q;
   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.mmu_read     = rd_q;
   assign bus.mmu_write    = wr_q;
   assign bus.mmu_bytemode = byte_q;
   assign bus.mmu_addr     = addr_q;
   assign bus.mmu_wdata    = wdata_q;

   assign bus.stall_req =
      (bus.if_req  & ~if_ack_w) |
      (bus.mem_req & ~mem_ack_w);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter.
// Timeline model plus directed and random steps.
module tb_mem_arbiter;

   localparam int W = 1;
   localparam logic [31:0] KEY = 32'hA401000F;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] exp_mrd;
   logic [31:0] exp_ird;
   logic [31:0] exp_wd;

   mem_arbiter_if b1 ();
   mem_arbiter_if b0 ();
   mem_arbiter_if b3 ();

   assign b1.mmu_rdata = b1.mmu_addr ^ KEY;
   assign b0.mmu_rdata = b0.mmu_addr ^ KEY;
   assign b3.mmu_rdata = b3.mmu_addr ^ KEY;

   mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));
   mem_arbiter #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .bus(b0));
   mem_arbiter #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .bus(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr(input int which);
      if (which == 0) begin
         b0.if_req = 0; b0.if_addr = 0;
         b0.mem_req = 0; b0.mem_we = 0;
         b0.mem_byte = 0; b0.mem_addr = 0;
         b0.mem_wdata = 0;
      end else if (which == 3) begin
         b3.if_req = 0; b3.if_addr = 0;
         b3.mem_req = 0; b3.mem_we = 0;
         b3.mem_byte = 0; b3.mem_addr = 0;
         b3.mem_wdata = 0;
      end else begin
         b1.if_req = 0; b1.if_addr = 0;
         b1.mem_req = 0; b1.mem_we = 0;
         b1.mem_byte = 0; b1.mem_addr = 0;
         b1.mem_wdata = 0;
      end
   endtask

   // Served order: MEM first, then IF one access period later.
   task automatic scenario(
      input bit dm, input bit we, input bit by,
      input logic [31:0] ma, input logic [31:0] mw,
      input bit di, input logic [31:0] ia,
      input int drop);
      int s_mem, s_if, ack_m, ack_i, last;
      bit mreq, ireq, m_on, i_on;
      s_mem = -100;
      s_if  = -100;
      if (dm) begin
         s_mem = 0;
         if (di) s_if = W + 3;
      end else begin
         s_if = 0;
      end
      ack_m = dm ? s_mem + W + 2 : -1;
      ack_i = di ? s_if + W + 2 : -1;
      last  = (ack_m > ack_i ? ack_m : ack_i) + 1;
      b1.mem_req = dm; b1.mem_we = we;
      b1.mem_byte = by; b1.mem_addr = ma;
      b1.mem_wdata = mw;
      b1.if_req = di; b1.if_addr = ia;
      if (dm && we) exp_wd = mw;
      mreq = dm;
      ireq = di;
      for (int c = 1; c <= last; c++) begin
         step();
         m_on = dm && c >= s_mem + 1 &&
                c <= s_mem + W + 1;
         i_on = di && c >= s_if + 1 &&
                c <= s_if + W + 1;
         if (dm && c == ack_m && !we)
            exp_mrd = ma ^ KEY;
         if (di && c == ack_i)
            exp_ird = ia ^ KEY;
         chk("mmu_read", b1.mmu_read,
             32'((m_on && !we) || i_on));
         chk("mmu_write", b1.mmu_write,
             32'(m_on && we));
         chk("mmu_bytemode", b1.mmu_bytemode,
             32'(m_on && by));
         if (m_on) chk("mmu_addr_mem", b1.mmu_addr, ma);
         if (i_on) chk("mmu_addr_if", b1.mmu_addr, ia);
         chk("mmu_wdata", b1.mmu_wdata, exp_wd);
         chk("mem_ack", b1.mem_ack, 32'(c == ack_m));
         chk("if_ack", b1.if_ack, 32'(c == ack_i));
         chk("mem_rdata", b1.mem_rdata, exp_mrd);
         chk("if_rdata", b1.if_rdata, exp_ird);
         chk("stall_req", b1.stall_req,
             32'((mreq && c != ack_m) ||
                 (ireq && c != ack_i)));
         if (c == ack_m || (drop > 0 && c == drop)) begin
            mreq = 0;
            b1.mem_req = 0;
         end
         if (c == ack_i) begin
            ireq = 0;
            b1.if_req = 0;
         end
      end
   endtask

   initial begin
      int ack0, ack3;
      checks = 0;
      errors = 0;
      exp_mrd = 0;
      exp_ird = 0;
      exp_wd = 0;
      rst_n = 1'b0;
      clr(0); clr(1); clr(3);
      step();
      step();
      chk("rst_read", b1.mmu_read, 0);
      chk("rst_write", b1.mmu_write, 0);
      chk("rst_byte", b1.mmu_bytemode, 0);
      chk("rst_addr", b1.mmu_addr, 0);
      chk("rst_wdata", b1.mmu_wdata, 0);
      chk("rst_if_rdata", b1.if_rdata, 0);
      chk("rst_mem_rdata", b1.mem_rdata, 0);
      chk("rst_acks", {b1.if_ack, b1.mem_ack}, 0);
      chk("rst_stall", b1.stall_req, 0);
      rst_n = 1'b1;
      step();

      scenario(0, 0, 0, 0, 0, 1, 32'h80000000, 0);
      chk("fetch_word", b1.if_rdata, 32'h2401000F);
      scenario(1, 0, 0, 32'h80400010, 0,
               1, 32'h80000004, 0);
      scenario(1, 1, 1, 32'h80000003, 32'h000000AB,
               0, 0, 0);
      scenario(1, 0, 0, 32'h80000100, 0, 0, 0, 1);
      scenario(1, 1, 0, 32'h80001000, 32'h12345678,
               1, 32'h80000020, 1);

      for (int i = 0; i < 30; i++) begin
         bit dm, di;
         dm = 1'($urandom);
         di = 1'($urandom);
         if (!dm && !di) di = 1;
         scenario(dm, 1'($urandom), 1'($urandom),
                  $urandom, $urandom, di, $urandom,
                  int'($urandom_range(0, 2)));
      end

      b1.mem_req = 1; b1.mem_we = 0;
      b1.mem_byte = 0; b1.mem_addr = 32'h80000200;
      step();
      chk("pre_rst_read", b1.mmu_read, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_read", b1.mmu_read, 0);
      chk("arst_write", b1.mmu_write, 0);
      chk("arst_addr", b1.mmu_addr, 0);
      chk("arst_if_rdata", b1.if_rdata, 0);
      chk("arst_mem_rdata", b1.mem_rdata, 0);
      chk("arst_acks", {b1.if_ack, b1.mem_ack}, 0);
      clr(1);
      exp_mrd = 0;
      exp_ird = 0;
      exp_wd = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("inrst_ack", b1.mem_ack, 0);
         chk("inrst_read", b1.mmu_read, 0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk("post_rst_ack", b1.mem_ack, 0);
         chk("post_rst_read", b1.mmu_read, 0);
      end
      scenario(1, 0, 0, 32'h80000300, 0, 0, 0, 0);

      ack0 = -1;
      ack3 = -1;
      b0.if_req = 1; b0.if_addr = 32'h80000040;
      b3.if_req = 1; b3.if_addr = 32'h80000080;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (b0.if_ack === 1'b1 && ack0 < 0) begin
            ack0 = c;
            b0.if_req = 0;
            chk("w0_rdata", b0.if_rdata,
                32'h80000040 ^ KEY);
         end
         if (b3.if_ack === 1'b1 && ack3 < 0) begin
            ack3 = c;
            b3.if_req = 0;
            chk("w3_rdata", b3.if_rdata,
                32'h80000080 ^ KEY);
         end
      end
      chk("w0_ack_cycle", ack0, 2);
      chk("w3_ack_cycle", ack3, 5);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
